// File: rtl/ehgu_sync_fifo.sv
// Single-clock FIFO with registered 1-cycle read data and count-derived status flags.
// Define EHGU_SYNC_FIFO_ERR_EN to add the sticky overflow/underflow flags.
module ehgu_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   pop,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_out_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
`ifdef EHGU_SYNC_FIFO_ERR_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             dov_q, dov_d;
  logic             full_w, empty_w;
  logic             push_acc, pop_acc;

  // Request semantics: push is taken only when full=0 and pop only when empty=0;
  // a refused request is a pure no-op. Popped data appears one cycle later,
  // qualified by a single-cycle data_out_valid pulse.
  assign full_w   = (count_q == DEPTH_C);
  assign empty_w  = (count_q == '0);
  assign push_acc = push && !full_w;
  assign pop_acc  = pop && !empty_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    dov_d      = 1'b0;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
      dov_d      = 1'b1;
    end
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      dov_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      dov_q      <= dov_d;
    end
  end

  // Storage is not cleared by reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef EHGU_SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  || (push && full_w);
      underflow_q <= underflow_q || (pop && empty_w);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign data_out       = data_out_q;
  assign data_out_valid = dov_q;
  assign full           = full_w;
  assign empty          = empty_w;
  assign count          = count_q;
  assign almost_full    = (int'(count_q) >= AF_THRESH);
  assign almost_empty   = (int'(count_q) <= AE_THRESH);

endmodule

// File: tb/tb_ehgu_sync_fifo.sv
// Bench for ehgu_sync_fifo: DEPTH=4 vector table and corner sequences, DEPTH=8 thresholds
// and randomized traffic against a queue model.
module tb_ehgu_sync_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=4 instance (default thresholds AF=2, AE=2)
  logic       p4 = 1'b0, q4 = 1'b0;
  logic [7:0] d4 = '0;
  logic [7:0] dout4;
  logic       dov4, full4, empty4, af4, ae4;
  logic [2:0] cnt4;
  // DEPTH=8 instance (AF=6, AE=2)
  logic       p8 = 1'b0, q8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] dout8;
  logic       dov8, full8, empty8, af8, ae8;
  logic [3:0] cnt8;
`ifdef EHGU_SYNC_FIFO_ERR_EN
  logic ov4, uf4, ov8, uf8;
`endif

  ehgu_sync_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .push(p4), .data_in(d4), .pop(q4),
    .data_out(dout4), .data_out_valid(dov4), .full(full4), .empty(empty4),
    .almost_full(af4), .almost_empty(ae4), .count(cnt4)
`ifdef EHGU_SYNC_FIFO_ERR_EN
    , .overflow(ov4), .underflow(uf4)
`endif
  );

  ehgu_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut8 (
    .clk(clk), .rst(rst), .push(p8), .data_in(d8), .pop(q8),
    .data_out(dout8), .data_out_valid(dov8), .full(full8), .empty(empty8),
    .almost_full(af8), .almost_empty(ae8), .count(cnt8)
`ifdef EHGU_SYNC_FIFO_ERR_EN
    , .overflow(ov8), .underflow(uf8)
`endif
  );

  // ---------------- checking helpers ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table (DEPTH=4) ----------------
  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [2:0] cnt;
    logic       full, empty, af, ae, dov;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic p, logic q, logic [7:0] d, logic [2:0] c, logic f, logic e,
                              logic af, logic ae, logic v, logic [7:0] o);
    vec_t r;
    r.push = p; r.pop = q; r.din = d; r.cnt = c; r.full = f; r.empty = e;
    r.af = af; r.ae = ae; r.dov = v; r.dout = o;
    return r;
  endfunction

  function automatic logic [31:0] pack4();
    return {16'h0, cnt4, full4, empty4, af4, ae4, dov4, dout4};
  endfunction

  // ---------------- scoreboard for DEPTH=8 ----------------
  logic [7:0] exp_q[$];
  logic [7:0] last8 = '0;
  logic       m_ov8 = 1'b0, m_uf8 = 1'b0;

  task automatic do8(input logic p, input logic q, input logic [7:0] d, input string name);
    int  sz;
    logic exp_dov;
    logic [31:0] exp_v, act_v;
    sz = exp_q.size();
    if (p && sz == 8) m_ov8 = 1'b1;
    if (q && sz == 0) m_uf8 = 1'b1;
    exp_dov = 1'b0;
    if (q && sz > 0) begin
      exp_dov = 1'b1;
      last8 = exp_q.pop_front();
    end
    if (p && sz < 8) exp_q.push_back(d);
    p8 = p; q8 = q; d8 = d;
    tick();
    sz = exp_q.size();
    exp_v = {16'h0, 4'(sz), (sz == 8), (sz == 0), (sz >= 6), (sz <= 2), exp_dov, last8};
    act_v = {16'h0, cnt8, full8, empty8, af8, ae8, dov8, dout8};
    check(name, act_v, exp_v);
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = mk(1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 8'h00);
    tbl[1]  = mk(1, 0, 8'h22, 2, 0, 0, 1, 1, 0, 8'h00);
    tbl[2]  = mk(1, 0, 8'h33, 3, 0, 0, 1, 0, 0, 8'h00);
    tbl[3]  = mk(1, 0, 8'h44, 4, 1, 0, 1, 0, 0, 8'h00);
    tbl[4]  = mk(1, 0, 8'h55, 4, 1, 0, 1, 0, 0, 8'h00);
    tbl[5]  = mk(1, 1, 8'h66, 3, 0, 0, 1, 0, 1, 8'h11);
    tbl[6]  = mk(0, 1, 8'h00, 2, 0, 0, 1, 1, 1, 8'h22);
    tbl[7]  = mk(0, 0, 8'h00, 2, 0, 0, 1, 1, 0, 8'h22);
    tbl[8]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h33);
    tbl[9]  = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h44);
    tbl[10] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 8'h44);
    tbl[11] = mk(1, 1, 8'hAA, 1, 0, 0, 0, 1, 0, 8'h44);
    tbl[12] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'hAA);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_dut4", pack4(), {16'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    check("reset_dut8", {16'h0, cnt8, full8, empty8, af8, ae8, dov8, dout8},
          {16'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});

    for (int i = 0; i < 13; i++) begin
      p4 = tbl[i].push; q4 = tbl[i].pop; d4 = tbl[i].din;
      tick();
      check($sformatf("table_row%0d", i), pack4(),
            {16'h0, tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae,
             tbl[i].dov, tbl[i].dout});
    end
    p4 = 0; q4 = 0;
`ifdef EHGU_SYNC_FIFO_ERR_EN
    check("overflow_set", {31'h0, ov4}, 32'h1);
    check("underflow_set", {31'h0, uf4}, 32'h1);
`endif

    // wrap-around: data 0..9 streamed through with one entry in flight
    p4 = 1; d4 = 8'd0;
    tick();
    for (int i = 1; i < 10; i++) begin
      p4 = 1; q4 = 1; d4 = 8'(i);
      tick();
      check($sformatf("wrap_%0d", i - 1), {23'h0, dov4, dout4}, {23'h0, 1'b1, 8'(i - 1)});
    end
    p4 = 0; q4 = 1;
    tick();
    check("wrap_9", {23'h0, dov4, dout4}, {23'h0, 1'b1, 8'd9});
    q4 = 0;
    check("wrap_empty", {29'h0, cnt4}, 32'h0);

    // reset mid-operation, one cycle after a pop, with a concurrent push
    for (int i = 0; i < 3; i++) begin
      p4 = 1; d4 = 8'hA1 + 8'(i);
      tick();
    end
    p4 = 1; q4 = 1; d4 = 8'hA4;
    tick();
    check("pre_reset", {22'h0, cnt4, dov4}, {22'h0, 3'd3, 1'b1});
    rst = 1; p4 = 1; q4 = 0; d4 = 8'hBB;
    tick();
    rst = 0; p4 = 0;
    check("mid_reset", pack4(), {16'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
`ifdef EHGU_SYNC_FIFO_ERR_EN
    check("err_cleared", {30'h0, ov4, uf4}, 32'h0);
`endif
    p4 = 1; d4 = 8'h77;
    tick();
    p4 = 0; q4 = 1;
    tick();
    q4 = 0;
    check("post_reset_read", {20'h0, cnt4, dov4, dout4}, {20'h0, 3'd0, 1'b1, 8'h77});

    // DEPTH=8 threshold ramp, then drain (dut8 went through the reset as well)
    exp_q.delete();
    last8 = '0; m_ov8 = 0; m_uf8 = 0;
    for (int k = 1; k <= 6; k++) do8(1'b1, 1'b0, 8'(8'h40 + k), $sformatf("thresh_push%0d", k));
    for (int k = 0; k < 7; k++) do8(1'b0, 1'b1, 8'h00, $sformatf("thresh_drain%0d", k));

    // randomized traffic: push-heavy phase then pop-heavy phase
    for (int c = 0; c < 400; c++) begin
      int pr;
      pr = (c < 200) ? 70 : 30;
      do8(($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < (100 - pr)),
          8'($urandom_range(0, 255)), "random");
    end
    p8 = 0; q8 = 0;
`ifdef EHGU_SYNC_FIFO_ERR_EN
    check("rand_err_flags", {30'h0, ov8, uf8}, {30'h0, m_ov8, m_uf8});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
